// File: rtl/ulpi_reg_engine.sv
// ULPI link-side register access engine: PHY reset sequencing, queued register
// reads/writes with abort-retry and timeout, and RX CMD capture while idle.
module ulpi_reg_engine #(
  parameter int unsigned RST_CYCLES     = 60,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       CLKOUT,
  input  logic       reset,
  output logic       phy_rst,
  input  logic       DIR,
  input  logic       NXT,
  output logic       STP,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rxcmd_valid,
  output logic [7:0] rxcmd_data,
  output logic       busy
);

  localparam int unsigned       RTY_W    = $clog2(RETRY_MAX + 2);
  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_LIM  = RTY_W'(RETRY_MAX);

  typedef enum logic [3:0] {
    ST_RST_ASSERT = 4'd0,
    ST_RST_WAIT   = 4'd1,
    ST_IDLE       = 4'd2,
    ST_W_CMD      = 4'd3,
    ST_W_DATA     = 4'd4,
    ST_W_STP      = 4'd5,
    ST_R_CMD      = 4'd6,
    ST_R_TURN     = 4'd7,
    ST_R_DATA     = 4'd8,
    ST_R_END      = 4'd9,
    ST_RX         = 4'd10
  } state_e;

  // Byte the link places on the bus in a given state; everything else is ULPI idle.
  function automatic logic [7:0] tx_byte(input state_e st, input logic [5:0] addr,
                                         input logic [7:0] wdata);
    logic [7:0] b;
    case (st)
      ST_W_CMD:  b = {2'b10, addr};
      ST_W_DATA: b = wdata;
      ST_R_CMD:  b = {2'b11, addr};
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic              dir_q;
  logic              pend_q, pend_d;
  logic              write_q, write_d;
  logic [5:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              phy_rst_q, phy_rst_d;
  logic              stp_q, stp_d;
  logic [7:0]        data_o_q, data_o_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic              rxcmd_valid_q, rxcmd_valid_d;
  logic [7:0]        rxcmd_data_q, rxcmd_data_d;
  logic              busy_q, busy_d;
  logic              link_idle_s, tmo_s, hs_s, abort_s, timeout_s;

  // The link may drive only when the PHY has released the bus for a full turnaround cycle.
  assign link_idle_s = ~DIR & ~dir_q;
  assign tmo_s       = (cnt_q == TMO_LAST);
  assign cmd_ready   = (state_q == ST_IDLE) & link_idle_s;
  assign hs_s        = cmd_valid & cmd_ready;

  assign data_oe     = link_idle_s;
  assign phy_rst     = phy_rst_q;
  assign STP         = stp_q;
  assign data_o      = data_o_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rxcmd_valid = rxcmd_valid_q;
  assign rxcmd_data  = rxcmd_data_q;
  assign busy        = busy_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    pend_d        = pend_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    phy_rst_d     = phy_rst_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rxcmd_valid_d = 1'b0;
    rxcmd_data_d  = rxcmd_data_q;
    abort_s       = 1'b0;
    timeout_s     = 1'b0;

    case (state_q)
      ST_RST_ASSERT: begin
        if (cnt_q == RST_LAST) begin
          phy_rst_d = 1'b0;
          state_d   = ST_RST_WAIT;
        end else begin
          phy_rst_d = 1'b1;
        end
      end
      ST_RST_WAIT: begin
        if (!DIR) state_d = ST_IDLE;
        else      state_d = ST_RST_WAIT;
      end
      ST_IDLE: begin
        if (DIR) begin
          state_d = ST_RX;
        end else if (hs_s) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          retry_d = '0;
          pend_d  = 1'b0;
          state_d = cmd_write ? ST_W_CMD : ST_R_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_W_CMD, ST_W_DATA, ST_R_CMD: begin
        // DIR wins over a simultaneous NXT: the PHY has taken the bus.
        if (DIR) begin
          abort_s = 1'b1;
        end else if (NXT) begin
          case (state_q)
            ST_W_CMD:  state_d = ST_W_DATA;
            ST_W_DATA: state_d = ST_W_STP;
            default:   state_d = ST_R_TURN;
          endcase
        end else if (tmo_s) begin
          timeout_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_W_STP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 8'h00;
        state_d     = ST_IDLE;
      end
      ST_R_TURN: begin
        if (DIR)        state_d   = ST_R_DATA;
        else if (tmo_s) timeout_s = 1'b1;
        else            state_d   = ST_R_TURN;
      end
      ST_R_DATA: begin
        rdata_d = data_i;
        state_d = ST_R_END;
      end
      ST_R_END: begin
        if (!DIR) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata_q;
          state_d     = ST_IDLE;
        end else if (tmo_s) begin
          timeout_s = 1'b1;
        end else begin
          state_d = ST_R_END;
        end
      end
      ST_RX: begin
        if (!DIR) begin
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = write_q ? ST_W_CMD : ST_R_CMD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!NXT) begin
          rxcmd_valid_d = 1'b1;
          rxcmd_data_d  = data_i;
        end else begin
          rxcmd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RST_ASSERT;
      end
    endcase

    case ({abort_s, timeout_s})
      2'b10: begin
        state_d = ST_RX;
        if (retry_q >= RTY_LIM) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          pend_d      = 1'b0;
        end else begin
          retry_d = retry_q + 1'b1;
          pend_d  = 1'b1;
        end
      end
      2'b01: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 8'h00;
        state_d     = DIR ? ST_RX : ST_IDLE;
      end
      default: ;
    endcase

    cnt_d    = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    data_o_d = tx_byte(state_d, addr_d, wdata_d);
    stp_d    = (state_d == ST_W_STP);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; reset forces a full PHY reset sequence.
  always_ff @(posedge CLKOUT or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RST_ASSERT;
      cnt_q         <= '0;
      retry_q       <= '0;
      dir_q         <= 1'b1;
      pend_q        <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= 6'h00;
      wdata_q       <= 8'h00;
      rdata_q       <= 8'h00;
      phy_rst_q     <= 1'b1;
      stp_q         <= 1'b0;
      data_o_q      <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rxcmd_valid_q <= 1'b0;
      rxcmd_data_q  <= 8'h00;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      dir_q         <= DIR;
      pend_q        <= pend_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      phy_rst_q     <= phy_rst_d;
      stp_q         <= stp_d;
      data_o_q      <= data_o_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rxcmd_valid_q <= rxcmd_valid_d;
      rxcmd_data_q  <= rxcmd_data_d;
      busy_q        <= busy_d;
    end
  end

endmodule
